// File: rtl/traffic_ctrl.sv
// Two-road traffic light controller stepped by a 1 Hz tick, with a per-phase countdown.
// Optional pedestrian shortening of the north-south green is compiled in with PED_REQ_EN.
module traffic_ctrl #(
    parameter int GREEN_NS = 30,
    parameter int GREEN_EW = 20,
    parameter int YELLOW   = 3,
    parameter int PED_MIN  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [5:0] remain,
    output logic       ped_wait
);

    typedef enum logic [1:0] {
        NS_G = 2'd0,
        NS_Y = 2'd1,
        EW_G = 2'd2,
        EW_Y = 2'd3
    } state_t;

    localparam logic [5:0] T_NS  = 6'(GREEN_NS);
    localparam logic [5:0] T_EW  = 6'(GREEN_EW);
    localparam logic [5:0] T_Y   = 6'(YELLOW);
    localparam logic [5:0] T_PED = 6'(PED_MIN);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t state;
    logic   last_sec;

    assign last_sec = tick && (remain == 6'd1);

    // Lamps and remain are loaded together with the state so they never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= NS_G;
            remain   <= T_NS;
            ns_light <= LAMP_G;
            ew_light <= LAMP_R;
        end else begin
            case (state)
                NS_G: begin
                    if (last_sec) begin
                        state    <= NS_Y;
                        remain   <= T_Y;
                        ns_light <= LAMP_Y;
                        ew_light <= LAMP_R;
                    end
`ifdef PED_REQ_EN
                    else if (tick && ped_wait && (remain > T_PED)) begin
                        remain <= T_PED;
                    end
`endif
                    else if (tick) begin
                        remain <= remain - 6'd1;
                    end
                end
                NS_Y: begin
                    if (last_sec) begin
                        state    <= EW_G;
                        remain   <= T_EW;
                        ns_light <= LAMP_R;
                        ew_light <= LAMP_G;
                    end else if (tick) begin
                        remain <= remain - 6'd1;
                    end
                end
                EW_G: begin
                    if (last_sec) begin
                        state    <= EW_Y;
                        remain   <= T_Y;
                        ns_light <= LAMP_R;
                        ew_light <= LAMP_Y;
                    end else if (tick) begin
                        remain <= remain - 6'd1;
                    end
                end
                EW_Y: begin
                    if (last_sec) begin
                        state    <= NS_G;
                        remain   <= T_NS;
                        ns_light <= LAMP_G;
                        ew_light <= LAMP_R;
                    end else if (tick) begin
                        remain <= remain - 6'd1;
                    end
                end
                default: begin
                    state    <= NS_G;
                    remain   <= T_NS;
                    ns_light <= LAMP_G;
                    ew_light <= LAMP_R;
                end
            endcase
        end
    end

`ifdef PED_REQ_EN
    // Requests only count while north-south traffic is being served; entering EW_G serves them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_wait <= 1'b0;
        end else if ((state == NS_Y) && last_sec) begin
            ped_wait <= 1'b0;
        end else if (ped_req && ((state == NS_G) || (state == NS_Y))) begin
            ped_wait <= 1'b1;
        end
    end
`else
    logic ped_unused;
    assign ped_unused = ped_req;

    always_ff @(posedge clk) begin
        ped_wait <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl at default parameters; pedestrian checks follow PED_REQ_EN.
module tb_traffic_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [5:0] remain;
    logic       ped_wait;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    traffic_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .remain   (remain),
        .ped_wait (ped_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       tick;
        logic       ped;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [5:0] rem;
        logic       pw;
    } vec_t;

    // Drive at a falling edge, let one rising edge sample, return at the next falling edge.
    task automatic applyStimulus(input logic r, input logic t, input logic p);
        rst_n   = r;
        tick    = t;
        ped_req = p;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] ns, input logic [2:0] ew,
                               input logic [5:0] rem, input logic pw);
        total++;
        if (ns_light !== ns || ew_light !== ew || remain !== rem || ped_wait !== pw) begin
            bad++;
            $display("[TB] FAIL %s: got ns=%b ew=%b remain=%0d ped_wait=%b, want ns=%b ew=%b remain=%0d ped_wait=%b",
                     name, ns_light, ew_light, remain, ped_wait, ns, ew, rem, pw);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Both roads showing non-red at once is never allowed.
    always @(negedge clk) begin
        if (!$isunknown({ns_light, ew_light})) begin
            total++;
            if (ns_light != R && ew_light != R) begin
                bad++;
                $display("[TB] FAIL both_non_red: got ns=%b ew=%b, want one road red", ns_light, ew_light);
            end
        end
    end

    vec_t vecs[10];

    int          dur[4];
    logic [2:0]  nsl[4];
    logic [2:0]  ewl[4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, G, R, 6'd30, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, G, R, 6'd30, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, G, R, 6'd30, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, G, R, 6'd29, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, G, R, 6'd28, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, G, R, 6'd28, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, G, R, 6'd27, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, G, R, 6'd30, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, G, R, 6'd30, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, G, R, 6'd29, 1'b0};

        dur = '{30, 3, 20, 3};
        nsl = '{G, Y, R, R};
        ewl = '{R, R, G, Y};

        rst_n   = 1'b0;
        tick    = 1'b0;
        ped_req = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].tick, vecs[i].ped);
            checkOutput($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ew, vecs[i].rem, vecs[i].pw);
        end

        // Full cycle from reset: each phase of N shows N..1 then moves on with the next load.
        doReset();
        checkOutput("cycle_start", G, R, 6'd30, 1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int k = 1; k <= dur[p]; k++) begin
                ticks(1);
                if (k < dur[p])
                    checkOutput($sformatf("cycle_p%0d_t%0d", p, k), nsl[p], ewl[p], 6'(dur[p] - k), 1'b0);
                else
                    checkOutput($sformatf("cycle_p%0d_next", p), nsl[(p + 1) % 4], ewl[(p + 1) % 4],
                                6'(dur[(p + 1) % 4]), 1'b0);
            end
        end

        // Reset for one clock in EW_G with 7 seconds left.
        doReset();
        ticks(30 + 3 + 13);
        checkOutput("ew_g_rem7", R, G, 6'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("reset_mid_ew", G, R, 6'd30, 1'b0);

        // Long idle without tick mid-phase.
        ticks(32);
        checkOutput("idle_before", Y, R, 6'd1, 1'b0);
        for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_after", Y, R, 6'd1, 1'b0);
        ticks(1);
        checkOutput("idle_resume", R, G, 6'd20, 1'b0);

`ifdef PED_REQ_EN
        doReset();
        ticks(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ped_latch", G, R, 6'd25, 1'b1);
        ticks(1);
        checkOutput("ped_shorten", G, R, 6'd5, 1'b1);
        ticks(4);
        checkOutput("ped_last", G, R, 6'd1, 1'b1);
        ticks(1);
        checkOutput("ped_ns_y", Y, R, 6'd3, 1'b1);
        ticks(3);
        checkOutput("ped_served", R, G, 6'd20, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ped_ignored_ew", R, G, 6'd20, 1'b0);

        doReset();
        ticks(26);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ped_late_latch", G, R, 6'd4, 1'b1);
        ticks(1);
        checkOutput("ped_late_t1", G, R, 6'd3, 1'b1);
        ticks(2);
        checkOutput("ped_late_t3", G, R, 6'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("ped_reset_clear", G, R, 6'd30, 1'b0);
`else
        doReset();
        ticks(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("noped_req", G, R, 6'd25, 1'b0);
        ticks(1);
        checkOutput("noped_tick", G, R, 6'd24, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
